// File: rtl/dff8_pkg.sv
// Shared constants for the dff8 single-bit delay line.
package dff8_pkg;

   localparam int   DFF8_DEPTH_DEFAULT = 8;
   localparam logic DFF8_RESET_VAL     = 1'b0;
   localparam int   DFF8_FILTER_TAPS   = 3;

endpackage

// File: rtl/dff8_stage.sv
// One asynchronously reset flop; the building block of the dff8 chain and filter.
module dff8_stage #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff8.sv
// Fixed-latency single-bit delay line with complementary outputs.
// Define DFF8_GLITCH_FILTER_EN to add an output register that rejects pulses under 3 cycles.
module dff8
   import dff8_pkg::*;
#(
   parameter int   DEPTH     = DFF8_DEPTH_DEFAULT,
   parameter logic RESET_VAL = DFF8_RESET_VAL
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic qb
);

   logic [DEPTH-1:0] stage;

   if (DEPTH < 1 || DEPTH > 32) begin : g_bad_depth
      $error("dff8: DEPTH must be in the range 1..32");
   end

   // stage[0] captures d; each later stage takes its predecessor.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic stage_d;
      if (i == 0) begin : g_head
         assign stage_d = d;
      end else begin : g_link
         assign stage_d = stage[i-1];
      end
      dff8_stage #(.RESET_VAL(RESET_VAL)) u_stage (
         .clk   (clk),
         .reset (reset),
         .d     (stage_d),
         .q     (stage[i])
      );
   end

`ifdef DFF8_GLITCH_FILTER_EN
   if (DEPTH < DFF8_FILTER_TAPS) begin : g_bad_filter
      $error("dff8: the glitch filter needs DEPTH >= 3");
      assign q = RESET_VAL;
   end else begin : g_filter
      logic taps_agree;
      logic filt_d;
      // The oldest sample is only passed on once the two younger ones confirm it.
      assign taps_agree = (stage[DEPTH-1] == stage[DEPTH-2]) &&
                          (stage[DEPTH-2] == stage[DEPTH-3]);
      assign filt_d     = taps_agree ? stage[DEPTH-1] : q;
      dff8_stage #(.RESET_VAL(RESET_VAL)) u_filter (
         .clk   (clk),
         .reset (reset),
         .d     (filt_d),
         .q     (q)
      );
   end
`else
   assign q = stage[DEPTH-1];
`endif

   assign qb = ~q;

endmodule

// File: tb/tb_dff8.sv
// Directed bench for dff8: expected q per clock is queued by the driver and checked by a monitor.
module tb_dff8;
   import dff8_pkg::*;

   localparam int DEPTH = DFF8_DEPTH_DEFAULT;
`ifdef DFF8_GLITCH_FILTER_EN
   localparam int LAT = DEPTH + 1;
`else
   localparam int LAT = DEPTH;
`endif

   logic  clk = 1'b0;
   logic  reset;
   logic  d;
   logic  q;
   logic  qb;
   logic  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Pattern stream: d = i[0] for i = 0..4, then zeros; expected q after each edge.
   logic pat_d [14] = '{0,1,0,1,0,0,0,0,0,0,0,0,0,0};
`ifdef DFF8_GLITCH_FILTER_EN
   logic pat_e [14] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
   logic p2_d  [16] = '{0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
   logic p3_d  [16] = '{0,0,1,1,1,0,0,0,0,0,0,0,0,0,0,0};
   logic p3_e  [16] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,0,0,0};
`else
   logic pat_e [14] = '{0,0,0,0,0,0,0,0,1,0,1,0,0,0};
`endif

   dff8 #(.DEPTH(DEPTH), .RESET_VAL(DFF8_RESET_VAL)) dut (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q),
      .qb    (qb)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check_out(input string name, input logic e);
      checks++;
      if (q !== e || qb !== ~e) begin
         errors++;
         $display("FAIL %s/%s: got q=%b qb=%b, expected q=%b qb=%b at %0t",
                  phase, name, q, qb, e, ~e, $time);
      end
   endtask

   // driver: one sample per cycle, expected q after the following rising edge
   task automatic cycle(input logic dv, input logic ev);
      @(negedge clk);
      d = dv;
      exp_q.push_back(ev);
   endtask

   task automatic drain();
      @(posedge clk);
      #2;
   endtask

   task automatic assert_reset_now();
      reset = 1'b1;
      #1;
      check_out("async_assert", DFF8_RESET_VAL);
      repeat (2) begin
         @(negedge clk);
         check_out("reset_hold", DFF8_RESET_VAL);
      end
   endtask

   task automatic release_after_edge(input logic dv);
      @(posedge clk);
      #1;
      reset = 1'b0;
      d     = dv;
   endtask

   task automatic summary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   // monitor / scoreboard
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         check_out("stream", exp_q.pop_front());
      end
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      summary();
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      d     = 1'bx;
      #1;

      phase = "reset_x";
      assert_reset_now();

      phase = "latency";
      release_after_edge(1'b1);
      for (int k = 1; k <= 12; k++) cycle(1'b1, (k >= LAT));
      drain();

      phase = "mid_reset";
      #1;
      assert_reset_now();
      release_after_edge(1'b1);
      for (int k = 1; k <= 12; k++) cycle(1'b1, (k >= LAT));
      drain();

      phase = "pattern";
      assert_reset_now();
      release_after_edge(1'b0);
      for (int i = 0; i < 14; i++) cycle(pat_d[i], pat_e[i]);
      drain();

      // Release lands in the NBA region of the edge, so that edge still sees reset high.
      phase = "coincident";
      d = 1'b1;
      assert_reset_now();
      @(posedge clk);
      reset <= 1'b0;
      for (int k = 1; k <= 12; k++) cycle(1'b1, (k >= LAT));
      drain();

`ifdef DFF8_GLITCH_FILTER_EN
      phase = "pulse2";
      assert_reset_now();
      release_after_edge(1'b0);
      for (int i = 0; i < 16; i++) cycle(p2_d[i], 1'b0);
      drain();

      phase = "pulse3";
      assert_reset_now();
      release_after_edge(1'b0);
      for (int i = 0; i < 16; i++) cycle(p3_d[i], p3_e[i]);
      drain();
`endif

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d expected values left unchecked, expected 0", exp_q.size());
      end
      summary();
      $finish;
   end

endmodule
